seq_mul_unit: RTL and testbench

Multi-cycle arithmetic unit between the A/B operand registers and the O result register of the Aeolus datapath. It consumes Aout/Bout (4-bit) and produces an 8-bit result plus a one-cycle load strobe that drives LDO. The result is computed by shift-add multiplication over INPUT_WIDTH cycles, with optional restoring division. It is a start/busy/done handshake slave of the control sequencer.

---
 rtl/aeolus_alu_pkg.sv | 16 +
 rtl/seq_mul_unit_reg.sv | 20 ++
 rtl/seq_mul_unit.sv | 177 +++++++++++++++++
 tb/tb_seq_mul_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/aeolus_alu_pkg.sv
// Shared encodings and default widths for the Aeolus multi-cycle ALU.
package aeolus_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int DEF_INPUT_WIDTH  = 4;
    localparam int DEF_OUTPUT_WIDTH = 8;

endpackage

// File: rtl/seq_mul_unit_reg.sv
// Plain register with synchronous active-high reset and load enable.
module ResetEnableDFF #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/seq_mul_unit.sv
// Shift-add multiplier with start/busy/done handshake between the A/B and O registers.
// Define DIVIDE_EN to add restoring division selected by op=1.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the start edge
// RUN   | one shift-add (or shift-subtract) step per edge, INPUT_WIDTH edges
// DONE  | result register just loaded; done pulses for this cycle
module seq_mul_unit
    import aeolus_alu_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    op,
    input  logic [INPUT_WIDTH-1:0]  a_in,
    input  logic [INPUT_WIDTH-1:0]  b_in,
    output logic                    busy,
    output logic                    done,
    output logic [OUTPUT_WIDTH-1:0] result,
    output logic                    flag
);

    localparam int CNT_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    generate
        if (OUTPUT_WIDTH != 2 * INPUT_WIDTH) begin : g_width_check
            $error("seq_mul_unit: OUTPUT_WIDTH must equal 2*INPUT_WIDTH");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [INPUT_WIDTH-1:0]  a_q, a_d;
    logic [INPUT_WIDTH-1:0]  sh_q, sh_d;
    logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0] res_d;
    logic                    load_res;

`ifdef DIVIDE_EN
    logic [INPUT_WIDTH-1:0] b_q, b_d;
    logic                   op_q, op_d;
    logic                   flag_q, flag_d;
    logic [INPUT_WIDTH:0]   rem_sh;
`else
    logic unused_op;
    assign unused_op = op;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef DIVIDE_EN
            b_q     <= '0;
            op_q    <= OP_MUL;
            flag_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef DIVIDE_EN
            b_q     <= b_d;
            op_q    <= op_d;
            flag_q  <= flag_d;
`endif
        end
    end

    // sh_q is the right-shifting multiplier, or for division the dividend
    // shifting left out of the MSB while quotient bits enter at the LSB.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = '0;
        load_res = 1'b0;
`ifdef DIVIDE_EN
        b_d      = b_q;
        op_d     = op_q;
        flag_d   = flag_q;
        rem_sh   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    sh_d    = b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef DIVIDE_EN
                    b_d     = b_in;
                    op_d    = op;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
`ifdef DIVIDE_EN
                if (op_q == OP_DIV) begin
                    rem_sh = {acc_q[INPUT_WIDTH-1:0], sh_q[INPUT_WIDTH-1]};
                    if (rem_sh >= {1'b0, b_q}) begin
                        acc_d = OUTPUT_WIDTH'(rem_sh - {1'b0, b_q});
                        sh_d  = {sh_q[INPUT_WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = OUTPUT_WIDTH'(rem_sh);
                        sh_d  = {sh_q[INPUT_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (sh_q[0]) begin
                        acc_d = acc_q + (OUTPUT_WIDTH'(a_q) << cnt_q);
                    end
                    sh_d = sh_q >> 1;
                end
`else
                if (sh_q[0]) begin
                    acc_d = acc_q + (OUTPUT_WIDTH'(a_q) << cnt_q);
                end
                sh_d = sh_q >> 1;
`endif
                if (cnt_q == CNT_W'(INPUT_WIDTH - 1)) begin
                    load_res = 1'b1;
                    state_d  = DONE;
                    res_d    = acc_d;
`ifdef DIVIDE_EN
                    flag_d = 1'b0;
                    if (op_q == OP_DIV) begin
                        if (b_q == '0) begin
                            res_d  = {a_q, {INPUT_WIDTH{1'b1}}};
                            flag_d = 1'b1;
                        end else begin
                            res_d = {acc_d[INPUT_WIDTH-1:0], sh_d};
                        end
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ResetEnableDFF #(
        .DATA_WIDTH(OUTPUT_WIDTH)
    ) u_result_reg (
        .clk_i  (clk),
        .reset_i(reset),
        .en_i   (load_res),
        .d_i    (res_d),
        .q_o    (result)
    );

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

`ifdef DIVIDE_EN
    assign flag = flag_q;
`else
    assign flag = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: directed plan cases plus random operands vs. an arithmetic model.
module tb_seq_mul_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       op;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       flag;

    int n_err = 0;
    int n_chk = 0;

    int         lat;
    int         n_done;
    int         n_busy;
    int         n_partial;
    logic [7:0] r_cap;
    logic       f_cap;

    seq_mul_unit #(
        .INPUT_WIDTH (4),
        .OUTPUT_WIDTH(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .result(result),
        .flag  (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {flag, result} from plain arithmetic.
    function automatic logic [8:0] model(input int a, input int b, input logic o);
        int q;
        int r;
`ifdef DIVIDE_EN
        if (o) begin
            if (b == 0) return {1'b1, 4'(a), 4'hF};
            q = a / b;
            r = a % b;
            return {1'b0, 4'(r), 4'(q)};
        end
`endif
        q = o ? 0 : 0;
        r = q;
        return {1'b0, 8'(a * b + r)};
    endfunction

    // Issue one op and observe 10 cycles; cycle i is the one after edge E0+i.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic o, input bit spam);
        logic [7:0] prev;
        @(negedge clk);
        prev  = result;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        op    = o;
        @(posedge clk);
        lat = -1; n_done = 0; n_busy = 0; n_partial = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (spam) begin
                    a_in = 4'd2;
                    b_in = 4'd2;
                end else begin
                    start = 1'b0;
                    a_in  = 4'($urandom);
                    b_in  = 4'($urandom);
                    op    = 1'($urandom);
                end
            end
            if (spam && i == 5) start = 1'b0;
            if (busy) n_busy++;
            if (i < 4 && result !== prev) n_partial++;
            if (done) begin
                n_done++;
                if (lat < 0) begin
                    lat   = i;
                    r_cap = result;
                    f_cap = flag;
                end
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic o, input bit spam);
        logic [8:0] exp;
        exp = model(int'(a), int'(b), o);
        run_op(a, b, o, spam);
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_busy_cnt"}, n_busy, 5);
        chk({tag, "_partial"}, n_partial, 0);
        chk({tag, "_result"}, {24'd0, r_cap}, {24'd0, exp[7:0]});
        chk({tag, "_flag"}, {31'd0, f_cap}, {31'd0, exp[8]});
        chk({tag, "_hold"}, {24'd0, result}, {24'd0, exp[7:0]});
        chk({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic       ro;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst_flag", {31'd0, flag}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);

        check_op("mul_max", 4'hF, 4'hF, 1'b0, 1'b0);
        chk("mul_max_const", {24'd0, r_cap}, 32'hE1);

        check_op("mul_zero", 4'h0, 4'h9, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("zero_hold", {24'd0, result}, 32'h00);
        check_op("mul_ident", 4'h7, 4'h1, 1'b0, 1'b0);
        chk("mul_ident_const", {24'd0, r_cap}, 32'h07);

        check_op("busy_start", 4'h7, 4'h3, 1'b0, 1'b1);
        chk("busy_start_const", {24'd0, r_cap}, 32'h15);

        // Reset on the second RUN edge abandons the op with no done pulse.
        @(negedge clk);
        start = 1'b1; a_in = 4'h9; b_in = 4'h9; op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_result", {24'd0, result}, 0);
        chk("midrst_flag", {31'd0, flag}, 0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        check_op("after_rst", 4'h9, 4'h9, 1'b0, 1'b0);
        chk("after_rst_const", {24'd0, r_cap}, 32'h51);

`ifdef DIVIDE_EN
        check_op("div_13_4", 4'd13, 4'd4, 1'b1, 1'b0);
        chk("div_13_4_const", {24'd0, r_cap}, 32'h13);
        check_op("div_by_0", 4'd5, 4'd0, 1'b1, 1'b0);
        chk("div_by_0_const", {23'd0, f_cap, r_cap}, 32'h15F);
`else
        check_op("op1_mul", 4'd3, 4'd5, 1'b1, 1'b0);
        chk("op1_mul_const", {23'd0, f_cap, r_cap}, 32'h00F);
`endif

        for (int k = 0; k < 24; k++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            ro = 1'($urandom);
            if (k % 8 == 0) rb = 4'd0;
            check_op("rand", ra, rb, ro, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
